// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//
// Contents:
//   state_t   - class of a pipeline cycle; this is also the encoding of the
//               controller's registered 'state' output
//   REG_ZERO  - architectural $zero register. Writes to it never create a
//               real dependency.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DSTALL = 2'd1,
        ST_MSTALL = 2'd2,
        ST_REDIR  = 2'd3
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous active-low clear.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous clear to zero, active low
//   inc    - count up by one this cycle, unless the counter is already all-ones
//   q      - current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    // Once the counter reaches all-ones it holds there instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (inc && (q != {CNT_W{1'b1}})) begin
            q <= q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline, which has no forwarding.
//
// The controller drives the write-enables and bubble-loads (flushes) of the PC
// and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. Outputs are
// combinational and follow this priority: reset, then memory wait, then
// redirect, then data hazard, then run.
// The controller also keeps saturating performance counters and a sticky
// memory-timeout flag.
//
// Ports:
//   clk, rst_n                   clock; synchronous reset, active low
//   id_valid, id_rs, id_rt       instruction in ID and its source registers
//   id_use_rs, id_use_rt         the ID instruction really reads rs / rt
//   ex_rd/ex_we, mem_rd/mem_we,  destination register and RegWrite of the
//   wb_rd/wb_we                  in-flight instructions in EX, MEM and WB
//   mem_access, mem_ready        data memory handshake for the MEM stage
//   mem_redirect                 a branch, jump or jr resolved taken in MEM
//   pc_we..exmem_we              stage write enables
//   ifid_flush..memwb_flush      load a bubble into the stage register
//   pc_redirect                  PC mux selects the MEM-stage target
//   state                        class of the previous cycle
//   stall_cnt, flush_cnt         saturating performance counters
//   mem_timeout                  sticky; a memory wait lasted MEM_TIMEOUT cycles
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int WB_HAZARD   = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_we,
    input  logic [4:0]       mem_rd,
    input  logic             mem_we,
    input  logic [4:0]       wb_rd,
    input  logic             wb_we,
    input  logic             mem_access,
    input  logic             mem_ready,
    input  logic             mem_redirect,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             pc_redirect,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    localparam bit              WB_ON        = (WB_HAZARD != 0);
    localparam int              MT_W         = 16;
    localparam logic [MT_W-1:0] TIMEOUT_LAST = MT_W'(MEM_TIMEOUT - 1);

    logic            rs_match;
    logic            rt_match;
    logic            dhaz;
    logic            mwait;
    state_t          cur_class;
    state_t          state_q;
    logic            mwait_clr_n;
    logic [MT_W-1:0] mwait_cnt;

    // A source register conflicts with any older in-flight instruction that
    // will write it. With WB_HAZARD set, the WB stage also conflicts, because
    // the register file does not pass a same-cycle write through to a read.
    always_comb begin
        rs_match = (id_rs != REG_ZERO) &&
                   ((ex_we  && (ex_rd  == id_rs)) ||
                    (mem_we && (mem_rd == id_rs)) ||
                    (WB_ON && wb_we && (wb_rd == id_rs)));
        rt_match = (id_rt != REG_ZERO) &&
                   ((ex_we  && (ex_rd  == id_rt)) ||
                    (mem_we && (mem_rd == id_rt)) ||
                    (WB_ON && wb_we && (wb_rd == id_rt)));
        dhaz     = id_valid && ((id_use_rs && rs_match) || (id_use_rt && rt_match));
        mwait    = mem_access && !mem_ready;
    end

    // Classify the cycle and drive the pipeline controls.
    // A memory wait freezes everything up to EX/MEM and drops a bubble into
    // MEM/WB, and any pending redirect is held back until EX/MEM can advance.
    // A redirect squashes the three younger instructions and overrides a data
    // hazard, because the stalled instruction is being thrown away anyway.
    // A data hazard holds PC and IF/ID and loads a bubble into ID/EX.
    always_comb begin
        cur_class   = ST_RUN;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        pc_redirect = 1'b0;
        if (!rst_n) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (mwait) begin
            cur_class   = ST_MSTALL;
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_flush = 1'b1;
        end else if (mem_redirect) begin
            cur_class   = ST_REDIR;
            pc_redirect = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (dhaz) begin
            cur_class   = ST_DSTALL;
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_flush  = 1'b1;
        end
    end

    // Record the class of the cycle that just ended. Software reads it as
    // 'state'.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= cur_class;
        end
    end

    assign state = state_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   ((cur_class == ST_DSTALL) || (cur_class == ST_MSTALL)),
        .q     (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cur_class == ST_REDIR),
        .q     (flush_cnt)
    );

    // The wait-length counter only runs during an unbroken memory wait. Any
    // cycle without a wait clears it through its synchronous clear.
    assign mwait_clr_n = rst_n && mwait;

    sat_counter #(.CNT_W(MT_W)) u_mwait_cnt (
        .clk   (clk),
        .rst_n (mwait_clr_n),
        .inc   (mwait),
        .q     (mwait_cnt)
    );

    // Set the flag on the edge that takes the wait count to MEM_TIMEOUT.
    // The flag stays set until reset, and the pipe simply keeps waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_timeout <= 1'b0;
        end else if (mwait && (mwait_cnt >= TIMEOUT_LAST)) begin
            mem_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl.
//
// Two instances share every input:
//   dut_a - WB_HAZARD=0, MEM_TIMEOUT=255, CNT_W=16
//   dut_b - WB_HAZARD=1, MEM_TIMEOUT=4,   CNT_W=2
//
// Each step works as follows. Inputs are driven and the expected control
// vector and next state for both instances go onto a queue. Entries are popped
// and compared against the combinational outputs, and then against the
// registered state one clock later.
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    // Control vector: {pc_we, ifid_we, idex_we, exmem_we,
    //                  ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_redirect}
    localparam logic [8:0] C_RUN = 9'b1111_0000_0;
    localparam logic [8:0] C_DST = 9'b0011_0100_0;
    localparam logic [8:0] C_MST = 9'b0000_0001_0;
    localparam logic [8:0] C_RDR = 9'b1111_1110_1;
    localparam logic [8:0] C_RST = 9'b0000_1111_0;

    typedef struct {
        string      tag;
        logic [8:0] ctrl_a;
        logic [8:0] ctrl_b;
        logic [1:0] st_a;
        logic [1:0] st_b;
    } exp_t;

    exp_t sb[$];
    int   testCount = 0;
    int   failCount = 0;

    logic       clk;
    logic       rst_n;
    logic       id_valid, id_use_rs, id_use_rt;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic       ex_we, mem_we, wb_we;
    logic       mem_access, mem_ready, mem_redirect;

    logic        a_pc_we, a_ifid_we, a_idex_we, a_exmem_we;
    logic        a_ifid_flush, a_idex_flush, a_exmem_flush, a_memwb_flush, a_pc_redirect;
    logic [1:0]  a_state;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic        a_mem_timeout;

    logic        b_pc_we, b_ifid_we, b_idex_we, b_exmem_we;
    logic        b_ifid_flush, b_idex_flush, b_exmem_flush, b_memwb_flush, b_pc_redirect;
    logic [1:0]  b_state;
    logic [1:0]  b_stall_cnt, b_flush_cnt;
    logic        b_mem_timeout;

    logic [8:0] ctrl_a, ctrl_b;
    assign ctrl_a = {a_pc_we, a_ifid_we, a_idex_we, a_exmem_we,
                     a_ifid_flush, a_idex_flush, a_exmem_flush, a_memwb_flush, a_pc_redirect};
    assign ctrl_b = {b_pc_we, b_ifid_we, b_idex_we, b_exmem_we,
                     b_ifid_flush, b_idex_flush, b_exmem_flush, b_memwb_flush, b_pc_redirect};

    pipe_hazard_ctrl #(.WB_HAZARD(0), .MEM_TIMEOUT(255), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rd(ex_rd), .ex_we(ex_we),
        .mem_rd(mem_rd), .mem_we(mem_we), .wb_rd(wb_rd), .wb_we(wb_we),
        .mem_access(mem_access), .mem_ready(mem_ready), .mem_redirect(mem_redirect),
        .pc_we(a_pc_we), .ifid_we(a_ifid_we), .idex_we(a_idex_we), .exmem_we(a_exmem_we),
        .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush), .exmem_flush(a_exmem_flush),
        .memwb_flush(a_memwb_flush), .pc_redirect(a_pc_redirect), .state(a_state),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt), .mem_timeout(a_mem_timeout)
    );

    pipe_hazard_ctrl #(.WB_HAZARD(1), .MEM_TIMEOUT(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rd(ex_rd), .ex_we(ex_we),
        .mem_rd(mem_rd), .mem_we(mem_we), .wb_rd(wb_rd), .wb_we(wb_we),
        .mem_access(mem_access), .mem_ready(mem_ready), .mem_redirect(mem_redirect),
        .pc_we(b_pc_we), .ifid_we(b_ifid_we), .idex_we(b_idex_we), .exmem_we(b_exmem_we),
        .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush), .exmem_flush(b_exmem_flush),
        .memwb_flush(b_memwb_flush), .pc_redirect(b_pc_redirect), .state(b_state),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt), .mem_timeout(b_mem_timeout)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        id_valid     = 1'b0;
        id_use_rs    = 1'b0;
        id_use_rt    = 1'b0;
        id_rs        = 5'd0;
        id_rt        = 5'd0;
        ex_rd        = 5'd0;
        mem_rd       = 5'd0;
        wb_rd        = 5'd0;
        ex_we        = 1'b0;
        mem_we       = 1'b0;
        wb_we        = 1'b0;
        mem_access   = 1'b0;
        mem_ready    = 1'b1;
        mem_redirect = 1'b0;
    endtask

    task automatic applyStimulus(input string tag, input logic [8:0] ca, input logic [8:0] cb,
                                 input logic [1:0] sa, input logic [1:0] sbst);
        exp_t e;
        e.tag    = tag;
        e.ctrl_a = ca;
        e.ctrl_b = cb;
        e.st_a   = sa;
        e.st_b   = sbst;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        #1;
        e = sb.pop_front();
        checkVal({e.tag, "/ctrl_a"}, 32'(ctrl_a), 32'(e.ctrl_a));
        checkVal({e.tag, "/ctrl_b"}, 32'(ctrl_b), 32'(e.ctrl_b));
        @(posedge clk);
        #1;
        checkVal({e.tag, "/state_a"}, 32'(a_state), 32'(e.st_a));
        checkVal({e.tag, "/state_b"}, 32'(b_state), 32'(e.st_b));
    endtask

    task automatic step(input string tag, input logic [8:0] ca, input logic [8:0] cb,
                        input logic [1:0] sa, input logic [1:0] sbst);
        applyStimulus(tag, ca, cb, sa, sbst);
        checkOutput();
    endtask

    task automatic doReset(input string tag);
        clearInputs();
        rst_n = 1'b0;
        step(tag, C_RST, C_RST, ST_RUN, ST_RUN);
        rst_n = 1'b1;
    endtask

    task automatic checkCounters(input string tag, input int sa, input int sbv,
                                 input int fa, input int fb, input int ta, input int tb);
        checkVal({tag, "/stall_a"}, 32'(a_stall_cnt), sa);
        checkVal({tag, "/stall_b"}, 32'(b_stall_cnt), sbv);
        checkVal({tag, "/flush_a"}, 32'(a_flush_cnt), fa);
        checkVal({tag, "/flush_b"}, 32'(b_flush_cnt), fb);
        checkVal({tag, "/tmo_a"},   32'(a_mem_timeout), ta);
        checkVal({tag, "/tmo_b"},   32'(b_mem_timeout), tb);
    endtask

    // Directed sequence: each step drives inputs, then checks the controls and the state.
    initial begin
        clearInputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Reset held for two clocks.
        step("rst1", C_RST, C_RST, ST_RUN, ST_RUN);
        step("rst2", C_RST, C_RST, ST_RUN, ST_RUN);
        checkCounters("rst", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // RAW hazard against EX, then MEM, then WB only.
        clearInputs();
        id_valid = 1'b1; id_rs = 5'd8; id_use_rs = 1'b1; ex_we = 1'b1; ex_rd = 5'd8;
        step("raw_ex", C_DST, C_DST, ST_DSTALL, ST_DSTALL);
        ex_we = 1'b0; mem_we = 1'b1; mem_rd = 5'd8;
        step("raw_mem", C_DST, C_DST, ST_DSTALL, ST_DSTALL);
        mem_we = 1'b0; wb_we = 1'b1; wb_rd = 5'd8;
        step("raw_wb", C_RUN, C_DST, ST_RUN, ST_DSTALL);
        checkCounters("raw", 2, 3, 0, 0, 0, 0);

        // A $zero destination and an unused source never stall.
        clearInputs();
        id_valid = 1'b1; id_use_rs = 1'b1; id_rs = 5'd0; ex_we = 1'b1; ex_rd = 5'd0;
        step("zero_reg", C_RUN, C_RUN, ST_RUN, ST_RUN);
        clearInputs();
        id_valid = 1'b1; id_use_rs = 1'b0; id_rs = 5'd9; ex_we = 1'b1; ex_rd = 5'd9;
        step("unused_rs", C_RUN, C_RUN, ST_RUN, ST_RUN);
        id_use_rt = 1'b1; id_rt = 5'd9;
        step("raw_rt", C_DST, C_DST, ST_DSTALL, ST_DSTALL);
        id_valid = 1'b0;
        step("invalid_id", C_RUN, C_RUN, ST_RUN, ST_RUN);

        // A redirect wins over a data hazard in the same cycle.
        clearInputs();
        id_valid = 1'b1; id_rs = 5'd8; id_use_rs = 1'b1; ex_we = 1'b1; ex_rd = 5'd8;
        mem_redirect = 1'b1;
        step("redir_dhaz", C_RDR, C_RDR, ST_REDIR, ST_REDIR);
        checkCounters("redir", 3, 3, 1, 1, 0, 0);

        // A memory wait holds off a pending redirect until the memory is ready.
        doReset("rst_mw");
        mem_access = 1'b1; mem_ready = 1'b0; mem_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("mwait_redir", C_MST, C_MST, ST_MSTALL, ST_MSTALL);
        end
        mem_ready = 1'b1;
        step("mready_redir", C_RDR, C_RDR, ST_REDIR, ST_REDIR);
        checkCounters("mwait", 3, 3, 1, 1, 0, 0);

        // Timeout on dut_b (MEM_TIMEOUT=4) and saturation of its 2-bit counter.
        doReset("rst_tmo");
        mem_access = 1'b1; mem_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step("tmo_wait", C_MST, C_MST, ST_MSTALL, ST_MSTALL);
            checkVal("tmo_a_during", 32'(a_mem_timeout), 0);
            checkVal("tmo_b_during", 32'(b_mem_timeout), (i >= 4) ? 1 : 0);
        end
        mem_ready = 1'b1;
        step("tmo_ready", C_RUN, C_RUN, ST_RUN, ST_RUN);
        checkCounters("tmo", 6, 3, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
